// File: rtl/dma_copy.sv
// 6502-bus DMA initiator: the CPU programs SRC/DST/LEN and CTRL over the slave port, then the block copies LEN bytes over the master port.
// Optional macro DMA_FILL_EN adds a fill mode, which writes the byte held in reg 7 to every destination address.
module dma_copy #(
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic [7:0]        dbr,
   input  logic [7:0]        dbw,
   input  logic [2:0]        addr,
   input  logic              cs,
   input  logic              we,
   output logic              m_req,
   input  logic              m_gnt,
   output logic [ADDR_W-1:0] m_addr,
   output logic [7:0]        m_dbw,
   input  logic [7:0]        m_dbr,
   output logic              m_cs,
   output logic              m_we,
   output logic              irq
);
`ifdef DMA_FILL_EN
   localparam bit FILL_EN = 1'b1;
`else
   localparam bit FILL_EN = 1'b0;
`endif
   localparam int unsigned HI_W = ADDR_W - 8;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_CAP, S_WR} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] src_q, dst_q, len_q;
   logic [7:0]        fill_q;
   logic              src_fix_q, dst_fix_q, fill_mode_q, done_q, abort_q;

   logic              busy, cfg_wr, ctrl_wr, last_d;
   logic [ADDR_W-1:0] src_d, dst_d, len_d;
   logic [7:0]        rd_data;

   assign busy    = (state_q != S_IDLE);
   assign cfg_wr  = cs & we & ~busy;
   assign ctrl_wr = cs & we & (addr == 3'd6);
   assign src_d   = src_fix_q ? src_q : src_q + ADDR_W'(1);
   assign dst_d   = dst_fix_q ? dst_q : dst_q + ADDR_W'(1);
   assign len_d   = len_q - ADDR_W'(1);
   // A pending abort ends the transfer at the same point where the last byte would end it
   assign last_d  = (len_d == '0) | abort_q;
   assign irq     = done_q;

   always_comb begin
      rd_data = 8'h00;
      case (addr)
         3'd0: rd_data = src_q[7:0];
         3'd1: rd_data = 8'(src_q >> 8);
         3'd2: rd_data = dst_q[7:0];
         3'd3: rd_data = 8'(dst_q >> 8);
         3'd4: rd_data = len_q[7:0];
         3'd5: rd_data = 8'(len_q >> 8);
         3'd6: rd_data = {done_q, 3'b000, fill_mode_q, dst_fix_q, src_fix_q, busy};
         3'd7: rd_data = FILL_EN ? fill_q : 8'h00;
         default: rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         len_q       <= '0;
         fill_q      <= 8'h00;
         src_fix_q   <= 1'b0;
         dst_fix_q   <= 1'b0;
         fill_mode_q <= 1'b0;
         done_q      <= 1'b0;
         abort_q     <= 1'b0;
         dbr         <= 8'h00;
         m_req       <= 1'b0;
         m_cs        <= 1'b0;
         m_we        <= 1'b0;
         m_addr      <= '0;
         m_dbw       <= 8'h00;
      end else begin
         dbr <= (cs && !we) ? rd_data : 8'h00;

         // Configuration registers are frozen while a transfer runs
         if (cfg_wr) begin
            case (addr)
               3'd0: src_q[7:0]        <= dbw;
               3'd1: src_q[ADDR_W-1:8] <= HI_W'(dbw);
               3'd2: dst_q[7:0]        <= dbw;
               3'd3: dst_q[ADDR_W-1:8] <= HI_W'(dbw);
               3'd4: len_q[7:0]        <= dbw;
               3'd5: len_q[ADDR_W-1:8] <= HI_W'(dbw);
               3'd6: begin
                  src_fix_q   <= dbw[1];
                  dst_fix_q   <= dbw[2];
                  fill_mode_q <= FILL_EN & dbw[3];
               end
               3'd7: if (FILL_EN) fill_q <= dbw;
               default: ;
            endcase
         end
         if (ctrl_wr && busy && dbw[6]) abort_q <= 1'b1;
         // Clear first so a same-cycle completion below wins
         if (ctrl_wr && dbw[7]) done_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (ctrl_wr && dbw[0]) begin
                  if (len_q == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= S_REQ;
                     m_req   <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (abort_q) begin
                  state_q <= S_IDLE;
                  m_req   <= 1'b0;
                  done_q  <= 1'b1;
                  abort_q <= 1'b0;
               end else if (m_gnt) begin
                  m_cs <= 1'b1;
                  if (fill_mode_q) begin
                     state_q <= S_WR;
                     m_we    <= 1'b1;
                     m_addr  <= dst_q;
                     m_dbw   <= fill_q;
                  end else begin
                     state_q <= S_RD;
                     m_we    <= 1'b0;
                     m_addr  <= src_q;
                  end
               end
            end
            S_RD: begin
               if (m_cs) begin
                  state_q <= S_CAP;
                  m_cs    <= 1'b0;
               end else if (m_gnt) begin
                  m_cs <= 1'b1;
               end
            end
            S_CAP: begin
               m_dbw   <= m_dbr;
               src_q   <= src_d;
               state_q <= S_WR;
               m_cs    <= m_gnt;
               m_we    <= 1'b1;
               m_addr  <= dst_q;
            end
            S_WR: begin
               if (m_cs) begin
                  dst_q <= dst_d;
                  len_q <= len_d;
                  if (last_d) begin
                     state_q <= S_IDLE;
                     m_req   <= 1'b0;
                     m_cs    <= 1'b0;
                     m_we    <= 1'b0;
                     done_q  <= 1'b1;
                     abort_q <= 1'b0;
                  end else if (fill_mode_q) begin
                     m_cs   <= m_gnt;
                     m_addr <= dst_d;
                  end else begin
                     state_q <= S_RD;
                     m_cs    <= m_gnt;
                     m_we    <= 1'b0;
                     m_addr  <= src_q;
                  end
               end else if (m_gnt) begin
                  m_cs <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: register table, copy/fill transfers, grant loss, abort, wrap and mid-run reset.
module tb_dma_copy;
`ifdef DMA_FILL_EN
   localparam bit FILL_ON = 1'b1;
`else
   localparam bit FILL_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, cs, we, m_gnt, m_req, m_cs, m_we, irq;
   logic [7:0]  dbr, dbw, m_dbw, m_dbr;
   logic [2:0]  addr;
   logic [15:0] m_addr;

   logic [7:0]  rom [0:65535];
   logic [15:0] wr_a[$], rd_a[$];
   logic [7:0]  wr_d[$];
   int          req_cnt = 0, cs_cnt = 0;
   int          n_pass = 0, n_tot = 0;

   typedef struct {
      bit         wr;
      logic [2:0] a;
      logic [7:0] d;
   } vec_t;

   dma_copy #(.ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .dbr(dbr), .dbw(dbw), .addr(addr), .cs(cs), .we(we),
      .m_req(m_req), .m_gnt(m_gnt), .m_addr(m_addr), .m_dbw(m_dbw), .m_dbr(m_dbr),
      .m_cs(m_cs), .m_we(m_we), .irq(irq)
   );

   always #5 clk = ~clk;

   // Registered responder on the master bus plus a log of every bus cycle
   always @(posedge clk) begin
      if (m_req === 1'b1) req_cnt++;
      if (m_cs === 1'b1) begin
         cs_cnt++;
         if (m_we) begin
            wr_a.push_back(m_addr);
            wr_d.push_back(m_dbw);
         end else begin
            m_dbr <= rom[m_addr];
            rd_a.push_back(m_addr);
         end
      end
   end

   task automatic chk(input string name, input int unsigned got, input int unsigned exp);
      n_tot++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; we = 1'b1; addr = a; dbw = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      d = dbr;
      cs = 1'b0;
   endtask

   task automatic wr16(input logic [2:0] a, input logic [15:0] v);
      reg_wr(a, v[7:0]);
      reg_wr(3'(a + 3'd1), v[15:8]);
   endtask

   task automatic rd16(input logic [2:0] a, output logic [15:0] v);
      logic [7:0] lo, hi;
      reg_rd(a, lo);
      reg_rd(3'(a + 3'd1), hi);
      v = {hi, lo};
   endtask

   task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
      wr16(3'd0, s);
      wr16(3'd2, d);
      wr16(3'd4, n);
   endtask

   task automatic wait_bus(input bit we_v, input logic [15:0] a, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (m_cs === 1'b1 && m_we == we_v && m_addr == a) ok = 1'b1;
      end
   endtask

   task automatic wait_irq(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 200 && cyc < 0; i++) begin
         @(negedge clk);
         if (irq === 1'b1) cyc = i;
      end
   endtask

   task automatic chk_writes(input string name, input int base, input int n,
                             input logic [15:0] a0, input bit afix, input logic [7:0] d [4]);
      chk({name, " wr count"}, wr_a.size() - base, n);
      if (wr_a.size() - base == n)
         for (int i = 0; i < n; i++) begin
            chk($sformatf("%s wr%0d addr", name, i), wr_a[base+i], afix ? a0 : 16'(a0 + 16'(i)));
            chk($sformatf("%s wr%0d data", name, i), wr_d[base+i], d[i]);
         end
   endtask

   initial begin
      vec_t        tbl [20];
      logic [7:0]  v8;
      logic [15:0] v16;
      logic [7:0]  exp_d [4];
      bit          ok, req_ok;
      int          cyc, wb, rb, rq, cc, lowc;

      tbl = '{
         '{1, 3'd0, 8'h34}, '{1, 3'd1, 8'h12}, '{0, 3'd0, 8'h34}, '{0, 3'd1, 8'h12},
         '{1, 3'd2, 8'h78}, '{1, 3'd3, 8'h56}, '{0, 3'd2, 8'h78}, '{0, 3'd3, 8'h56},
         '{1, 3'd4, 8'hCD}, '{1, 3'd5, 8'hAB}, '{0, 3'd4, 8'hCD}, '{0, 3'd5, 8'hAB},
         '{1, 3'd6, 8'h06}, '{0, 3'd6, 8'h06}, '{1, 3'd7, 8'h5A}, '{0, 3'd7, FILL_ON ? 8'h5A : 8'h00},
         '{1, 3'd6, 8'h08}, '{0, 3'd6, FILL_ON ? 8'h08 : 8'h00}, '{1, 3'd6, 8'h00}, '{0, 3'd6, 8'h00}
      };

      for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
      rom[16'h0200] = 8'hA1; rom[16'h0201] = 8'hB2; rom[16'h0202] = 8'hC3;
      rom[16'hFFFF] = 8'h11; rom[16'h0000] = 8'h22;
      rom[16'h0500] = 8'h3C; rom[16'h0501] = 8'h4D; rom[16'h0502] = 8'h5E;
      for (int i = 0; i < 5; i++) rom[16'h0700 + i] = 8'(8'h90 + i);

      cs = 1'b0; we = 1'b0; addr = 3'd0; dbw = 8'h00; m_gnt = 1'b1; rst = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset dbr", dbr, 0);
      chk("reset m_req", m_req, 0);
      chk("reset m_cs", m_cs, 0);
      chk("reset m_we", m_we, 0);
      chk("reset m_addr", m_addr, 0);
      chk("reset irq", irq, 0);

      // Register map
      for (int i = 0; i < 20; i++) begin
         if (tbl[i].wr) reg_wr(tbl[i].a, tbl[i].d);
         else begin
            reg_rd(tbl[i].a, v8);
            chk($sformatf("tbl%0d reg%0d", i, tbl[i].a), v8, tbl[i].d);
         end
      end
      @(negedge clk);
      chk("dbr idle zero", dbr, 0);

      // Basic copy, 3 bytes
      reg_wr(3'd6, 8'h80);
      setup(16'h0200, 16'h0300, 16'd3);
      wb = wr_a.size(); rb = rd_a.size();
      reg_wr(3'd6, 8'h01);
      wait_bus(1'b0, 16'h0200, ok);
      chk("copy first rd", ok, 1);
      wait_irq(cyc);
      chk("copy cycles", cyc, 9);
      exp_d = '{8'hA1, 8'hB2, 8'hC3, 8'h00};
      chk_writes("copy", wb, 3, 16'h0300, 1'b0, exp_d);
      chk("copy rd count", rd_a.size() - rb, 3);
      chk("copy irq", irq, 1);
      rd16(3'd4, v16); chk("copy LEN", v16, 16'h0000);
      rd16(3'd0, v16); chk("copy SRC", v16, 16'h0203);
      rd16(3'd2, v16); chk("copy DST", v16, 16'h0303);
      reg_rd(3'd6, v8); chk("copy CTRL", v8, 8'h80);

      // Zero length
      reg_wr(3'd6, 8'h80);
      wr16(3'd4, 16'd0);
      rq = req_cnt; cc = cs_cnt;
      reg_wr(3'd6, 8'h01);
      chk("len0 irq next cycle", irq, 1);
      repeat (5) @(negedge clk);
      chk("len0 no m_req", req_cnt - rq, 0);
      chk("len0 no m_cs", cs_cnt - cc, 0);

      // Source wraps, destination fixed
      reg_wr(3'd6, 8'h80);
      setup(16'hFFFF, 16'h0010, 16'd2);
      wb = wr_a.size(); rb = rd_a.size();
      reg_wr(3'd6, 8'h05);
      wait_irq(cyc);
      chk("wrap cycles", cyc, 7);
      exp_d = '{8'h11, 8'h22, 8'h00, 8'h00};
      chk_writes("wrap", wb, 2, 16'h0010, 1'b1, exp_d);
      chk("wrap rd count", rd_a.size() - rb, 2);
      if (rd_a.size() - rb == 2) begin
         chk("wrap rd0", rd_a[rb], 16'hFFFF);
         chk("wrap rd1", rd_a[rb+1], 16'h0000);
      end
      rd16(3'd0, v16); chk("wrap SRC", v16, 16'h0001);
      rd16(3'd2, v16); chk("wrap DST", v16, 16'h0010);

      // Grant dropped for 4 cycles ahead of the second read
      reg_wr(3'd6, 8'h80);
      setup(16'h0500, 16'h0600, 16'd3);
      wb = wr_a.size();
      reg_wr(3'd6, 8'h01);
      wait_bus(1'b1, 16'h0600, ok);
      chk("gnt first wr", ok, 1);
      m_gnt = 1'b0; lowc = 0; req_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (m_cs === 1'b0) lowc++;
         if (m_req !== 1'b1) req_ok = 1'b0;
      end
      m_gnt = 1'b1;
      chk("gnt m_cs low cycles", lowc, 4);
      chk("gnt m_req held", req_ok, 1);
      @(negedge clk);
      chk("gnt resume m_cs", m_cs, 1);
      chk("gnt resume m_we", m_we, 0);
      chk("gnt resume addr", m_addr, 16'h0501);
      wait_irq(cyc);
      chk("gnt done", cyc > 0, 1);
      exp_d = '{8'h3C, 8'h4D, 8'h5E, 8'h00};
      chk_writes("gnt", wb, 3, 16'h0600, 1'b0, exp_d);

      // Abort during the second byte
      reg_wr(3'd6, 8'h80);
      setup(16'h0700, 16'h0800, 16'd5);
      wb = wr_a.size();
      reg_wr(3'd6, 8'h01);
      wait_bus(1'b0, 16'h0701, ok);
      chk("abort byte2 rd", ok, 1);
      reg_wr(3'd6, 8'h40);
      wait_irq(cyc);
      chk("abort done", cyc > 0, 1);
      repeat (3) @(negedge clk);
      exp_d = '{8'h90, 8'h91, 8'h00, 8'h00};
      chk_writes("abort", wb, 2, 16'h0800, 1'b0, exp_d);
      rd16(3'd4, v16); chk("abort LEN", v16, 16'd3);
      reg_wr(3'd6, 8'h80);
      chk("abort irq cleared", irq, 0);
      reg_rd(3'd6, v8); chk("abort CTRL", v8, 8'h00);

`ifdef DMA_FILL_EN
      // Fill mode: one write per clock, no reads, SRC untouched
      reg_wr(3'd7, 8'h5A);
      setup(16'h1234, 16'h0400, 16'd4);
      wb = wr_a.size(); rb = rd_a.size();
      reg_wr(3'd6, 8'h09);
      wait_bus(1'b1, 16'h0400, ok);
      chk("fill first wr", ok, 1);
      wait_irq(cyc);
      chk("fill cycles", cyc, 4);
      exp_d = '{8'h5A, 8'h5A, 8'h5A, 8'h5A};
      chk_writes("fill", wb, 4, 16'h0400, 1'b0, exp_d);
      chk("fill no reads", rd_a.size() - rb, 0);
      rd16(3'd0, v16); chk("fill SRC", v16, 16'h1234);
      reg_wr(3'd6, 8'h80);
      setup(16'h1234, 16'h0400, 16'd8);
      reg_wr(3'd6, 8'h09);
      wait_bus(1'b1, 16'h0402, ok);
`else
      reg_wr(3'd6, 8'h80);
      setup(16'h0200, 16'h0300, 16'd3);
      reg_wr(3'd6, 8'h01);
      wait_bus(1'b0, 16'h0201, ok);
`endif
      // Reset in the middle of a transfer
      chk("midrst bus active", ok, 1);
      #2 rst = 1'b1;
      #1;
      chk("midrst m_cs", m_cs, 0);
      chk("midrst m_req", m_req, 0);
      cc = cs_cnt;
      repeat (3) @(negedge clk);
      chk("midrst no bus", cs_cnt - cc, 0);
      rst = 1'b0;
      rd16(3'd4, v16); chk("midrst LEN", v16, 16'h0000);
      reg_rd(3'd6, v8); chk("midrst CTRL", v8, 8'h00);
      chk("midrst irq", irq, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
